// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder
//   Transmit side of the FIR sample interface. Buffers samples from a
//   valid/ready source in a small FIFO, primes the FIFO to half depth before
//   streaming, and then emits one o_valid strobe per rate tick toward the
//   filter input. A tick that finds the FIFO empty raises o_underrun instead.
//
//   Optional feature macro: FIR_FEEDER_ZERO_STUFF_EN
//     When defined, a phase counter 0..UPS-1 advances on every tick. Only
//     phase 0 pops a sample; the other phases emit a zero-valued strobe so
//     the filter sees an UPS-times zero-stuffed stream for interpolation.
//     When undefined, every tick pops and UPS is unused.

module fir_sample_feeder #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int RATE_W = 16,
  parameter int UPS    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_enable,
  input  logic [RATE_W-1:0]           i_rate,
  input  logic                        i_valid,
  input  logic signed [WIDTH-1:0]     i_data,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic signed [WIDTH-1:0]     o_data,
  output logic [$clog2(DEPTH):0]      o_level,
  output logic                        o_underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_HALF  = LW'(DEPTH / 2);
  localparam logic [RATE_W-1:0] CNT_ONE  = RATE_W'(1);
  localparam logic [RATE_W-1:0] CNT_ZERO = RATE_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Storage and bookkeeping
  logic signed [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]           wr_ptr_r;
  logic [AW-1:0]           rd_ptr_r;
  logic [LW-1:0]           level_r;
  logic [RATE_W-1:0]       cnt_r;
  state_t                  state_r;
  state_t                  state_nxt_s;

  // Output registers
  logic                    valid_r;
  logic signed [WIDTH-1:0] data_r;
  logic                    underrun_r;

  // Datapath decode
  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic tick_s;
  logic stuff_s;
  logic run_entry_s;

  assign full_s      = (level_r == LVL_FULL);
  assign empty_s     = (level_r == LVL_ZERO);
  assign push_s      = i_valid && !full_s;
  assign tick_s      = (state_r == ST_RUN) && i_enable && (cnt_r == CNT_ZERO);
  assign pop_s       = tick_s && !stuff_s && !empty_s;
  assign run_entry_s = (state_r == ST_PRIME) && (state_nxt_s == ST_RUN);

  assign o_ready    = !full_s;
  assign o_valid    = valid_r;
  assign o_data     = data_r;
  assign o_level    = level_r;
  assign o_underrun = underrun_r;

`ifdef FIR_FEEDER_ZERO_STUFF_EN
  localparam int PW = (UPS > 2) ? $clog2(UPS) : 1;
  localparam logic [PW-1:0] PH_ZERO = PW'(0);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [PW-1:0] PH_LAST = PW'(UPS - 1);

  logic [PW-1:0] phase_r;

  assign stuff_s = (phase_r != PH_ZERO);

  // Interpolation phase: advances per tick, cleared whenever not running
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= PH_ZERO;
    end else if ((state_r != ST_RUN) || !i_enable) begin
      phase_r <= PH_ZERO;
    end else if (tick_s) begin
      phase_r <= (phase_r == PH_LAST) ? PH_ZERO : (phase_r + PH_ONE);
    end else begin
      phase_r <= phase_r;
    end
  end
`else
  assign stuff_s = 1'b0;
`endif

  // Next-state logic for the IDLE / PRIME / RUN controller
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          state_nxt_s = ST_PRIME;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRIME: begin
        if (!i_enable) begin
          state_nxt_s = ST_IDLE;
        end else if (level_r >= LVL_HALF) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Rate divider: loaded on RUN entry, reloaded from i_rate on every tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (run_entry_s) begin
      cnt_r <= i_rate;
    end else if ((state_r == ST_RUN) && i_enable) begin
      if (cnt_r == CNT_ZERO) begin
        cnt_r <= i_rate;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave level unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= LVL_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  // Strobe generation: one cycle after a tick, carrying the popped head,
  // a stuffed zero, or an underrun flag when nothing was available
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      data_r     <= '0;
      underrun_r <= 1'b0;
    end else begin
      valid_r    <= tick_s && (stuff_s || !empty_s);
      underrun_r <= tick_s && !stuff_s && empty_s;
      if (pop_s) begin
        data_r <= mem_r[rd_ptr_r];
      end else if (tick_s && stuff_s) begin
        data_r <= '0;
      end else begin
        data_r <= data_r;
      end
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder
//   Directed bench for fir_sample_feeder with DEPTH=8, WIDTH=16, UPS=4.
//   Inputs change 1 time unit after each rising edge; outputs are sampled
//   at the same point, so every check sees the state left by that edge.

module tb_fir_sample_feeder;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int RATE_W = 16;
  localparam int UPS    = 4;

  logic                    clk;
  logic                    rst;
  logic                    i_enable;
  logic [RATE_W-1:0]       i_rate;
  logic                    i_valid;
  logic signed [WIDTH-1:0] i_data;
  logic                    o_ready;
  logic                    o_valid;
  logic signed [WIDTH-1:0] o_data;
  logic [$clog2(DEPTH):0]  o_level;
  logic                    o_underrun;

  int checks;
  int failures;

  fir_sample_feeder #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RATE_W (RATE_W),
    .UPS    (UPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (i_enable),
    .i_rate     (i_rate),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_level    (o_level),
    .o_underrun (o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_one(input int val);
    i_valid = 1'b1;
    i_data  = WIDTH'(val);
    cyc();
    i_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    i_enable = 1'b0;
    i_rate   = 16'd0;
    i_valid  = 1'b0;
    i_data   = 16'sd0;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_underrun", int'(o_underrun), 0);

    // T3: fill with 9 back-to-back pushes while disabled
    i_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      i_data = WIDTH'(k);
      cyc();
      chk($sformatf("t3_level_%0d", k), int'(o_level), (k < 8) ? k : 8);
      chk($sformatf("t3_ready_%0d", k), int'(o_ready), (k < 8) ? 1 : 0);
      chk($sformatf("t3_valid_%0d", k), int'(o_valid), 0);
    end
    i_valid = 1'b0;

    // T1: start streaming, then reset mid-run with a strobe in flight
    i_rate   = 16'd0;
    i_enable = 1'b1;
    cyc();
    chk("t1_valid_prime", int'(o_valid), 0);
    cyc();
    chk("t1_valid_runentry", int'(o_valid), 0);
    cyc();
    chk("t1_valid_first", int'(o_valid), 1);
    chk("t1_data_first", int'(o_data), 1);
    chk("t1_level_first", int'(o_level), 7);
    rst      = 1'b1;
    i_enable = 1'b0;
    cyc();
    chk("t1_valid_inrst", int'(o_valid), 0);
    cyc();
    rst = 1'b0;
    chk("t1_valid", int'(o_valid), 0);
    chk("t1_level", int'(o_level), 0);
    chk("t1_ready", int'(o_ready), 1);
    chk("t1_data", int'(o_data), 0);
    cyc();
    chk("t1_idle_valid", int'(o_valid), 0);
    chk("t1_idle_level", int'(o_level), 0);

`ifndef FIR_FEEDER_ZERO_STUFF_EN
    // T2: prime with 1..4 at i_rate=3, strobes every 4 cycles
    i_rate   = 16'd3;
    i_enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push_one(k);
    end
    chk("t2_level_primed", int'(o_level), 4);
    for (int c = 1; c <= 22; c++) begin
      cyc();
      chk($sformatf("t2_valid_c%0d", c), int'(o_valid),
          (c == 5 || c == 9 || c == 13 || c == 17) ? 1 : 0);
      chk($sformatf("t2_underrun_c%0d", c), int'(o_underrun), (c == 21) ? 1 : 0);
      if (c == 5 || c == 9 || c == 13 || c == 17) begin
        chk($sformatf("t2_data_c%0d", c), int'(o_data), (c - 1) / 4);
      end
      if (c == 21) begin
        chk("t2_data_hold", int'(o_data), 4);
      end
    end
    i_enable = 1'b0;
    cyc();
    chk("t2_stop_valid", int'(o_valid), 0);

    // T4: i_rate=0 drains 1..4 on consecutive cycles then underruns
    for (int k = 1; k <= 4; k++) begin
      push_one(k);
    end
    i_rate   = 16'd0;
    i_enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk($sformatf("t4_valid_c%0d", c), int'(o_valid), (c >= 3 && c <= 6) ? 1 : 0);
      chk($sformatf("t4_underrun_c%0d", c), int'(o_underrun), (c >= 7) ? 1 : 0);
      if (c >= 3) begin
        chk($sformatf("t4_data_c%0d", c), int'(o_data), (c <= 6) ? (c - 2) : 4);
      end
    end
    chk("t4_level", int'(o_level), 0);
    i_enable = 1'b0;
    cyc();
    chk("t4_stop_underrun", int'(o_underrun), 0);

    // T5: disable mid-run at level 3, then re-enable and re-prime
    for (int k = 21; k <= 26; k++) begin
      push_one(k);
    end
    chk("t5_level_loaded", int'(o_level), 6);
    i_enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
    end
    chk("t5_data_lastpop", int'(o_data), 23);
    chk("t5_level_mid", int'(o_level), 3);
    i_enable = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      chk($sformatf("t5_off_valid_c%0d", c), int'(o_valid), 0);
      chk($sformatf("t5_off_level_c%0d", c), int'(o_level), 3);
    end
    i_enable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("t5_prime_valid_c%0d", c), int'(o_valid), 0);
      chk($sformatf("t5_prime_level_c%0d", c), int'(o_level), 3);
    end
    push_one(27);
    chk("t5_level_4", int'(o_level), 4);
    chk("t5_valid_prepush", int'(o_valid), 0);
    cyc();
    chk("t5_valid_runentry", int'(o_valid), 0);
    cyc();
    chk("t5_valid_resume", int'(o_valid), 1);
    chk("t5_data_resume", int'(o_data), 24);
    chk("t5_level_resume", int'(o_level), 3);
    i_enable = 1'b0;
    cyc();
`else
    // T6: zero-stuffing at UPS=4, i_rate=0
    for (int k = 1; k <= 4; k++) begin
      push_one(k * 100);
    end
    i_rate   = 16'd0;
    i_enable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      chk($sformatf("t6_valid_c%0d", c), int'(o_valid), (c >= 3) ? 1 : 0);
      if (c >= 3) begin
        chk($sformatf("t6_data_c%0d", c), int'(o_data),
            (c == 3) ? 100 : ((c == 7) ? 200 : 0));
      end
    end
    chk("t6_level", int'(o_level), 2);
    i_enable = 1'b0;
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
